mem_access_unit: RTL and testbench

Memory-stage load/store unit between the execute stage and the word-addressed data cache. Accepts one load or store per request, converts the byte address to a word index, performs byte/halfword lane extraction with sign/zero extension on loads and read-modify-write for sub-word stores. Stalls the pipeline while a cache access is in flight and waits on the cache's `valid` handshake, so a real multi-cycle cache drops in without pipeline changes.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit between the execute stage and
// a word-addressed data cache.
//   ex_*      : request from execute (op, size, unsigned, byte addr, data, rd)
//   stall_o   : unit busy, upstream holds its request
//   wb_*      : registered load result with a one-cycle valid pulse
//   misaligned_o : one-cycle pulse when a request is rejected
//   cache_*   : word index, write strobe/data, completion handshake, read data
// Loads extract and extend a byte/half lane. Sub-word stores read the word,
// merge the new lane, then write the whole word back.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_op_i,
  input  logic [1:0]  ex_size_i,
  input  logic        ex_unsigned_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        misaligned_o,
  output logic        cache_write_valid_o,
  output logic [31:0] cache_addr_o,
  output logic [31:0] cache_wdata_o,
  input  logic        cache_valid_i,
  input  logic [31:0] cache_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_LD, S_RMW_RD, S_ST} state_e;

  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;
  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  // Store data; overwritten with the merged word after the RMW read.
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        mis_q, mis_d;

  logic        req_mem, req_bad;
  logic [4:0]  lane_sh;
  logic [31:0] rsh, ld_ext, lane_mask, merged;

  assign req_mem = ex_valid_i && (ex_op_i == OP_LD || ex_op_i == OP_ST);
  assign req_bad = (ex_size_i == 2'b11) ||
                   (ex_size_i == SZ_H && ex_addr_i[0]) ||
                   (ex_size_i == SZ_W && ex_addr_i[1:0] != 2'b00);

  // Little-endian lane offset in bits; halves are aligned so addr[1:0]*8
  // equals addr[1]*16 for them.
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign rsh     = cache_rdata_i >> lane_sh;

  always_comb begin
    ld_ext    = cache_rdata_i;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      SZ_B: begin
        ld_ext    = {{24{~uns_q & rsh[7]}}, rsh[7:0]};
        lane_mask = 32'h0000_00FF << lane_sh;
      end
      SZ_H: begin
        ld_ext    = {{16{~uns_q & rsh[15]}}, rsh[15:0]};
        lane_mask = 32'h0000_FFFF << lane_sh;
      end
      default: ;
    endcase
  end

  assign merged = (cache_rdata_i & ~lane_mask) | ((data_q << lane_sh) & lane_mask);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    data_d     = data_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    mis_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_mem) begin
          if (req_bad) begin
            mis_d = 1'b1;
          end else begin
            addr_d = ex_addr_i;
            size_d = ex_size_i;
            uns_d  = ex_unsigned_i;
            data_d = ex_wdata_i;
            rd_d   = ex_rd_i;
            if (ex_op_i == OP_LD)      state_d = S_LD;
            else if (ex_size_i == SZ_W) state_d = S_ST;
            else                        state_d = S_RMW_RD;
          end
        end
      end
      S_LD: begin
        if (cache_valid_i) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ld_ext;
          wb_rd_d    = rd_q;
          state_d    = S_IDLE;
        end
      end
      S_RMW_RD: begin
        if (cache_valid_i) begin
          data_d  = merged;
          state_d = S_ST;
        end
      end
      S_ST: begin
        if (cache_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      data_q     <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      mis_q      <= mis_d;
    end
  end

  assign stall_o             = (state_q != S_IDLE);
  assign wb_valid_o          = wb_valid_q;
  assign wb_data_o           = wb_data_q;
  assign wb_rd_o             = wb_rd_q;
  assign misaligned_o        = mis_q;
  assign cache_write_valid_o = (state_q == S_ST);
  assign cache_addr_o        = (state_q == S_IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
  assign cache_wdata_o       = (state_q == S_ST) ? data_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 16-word cache model with programmable latency,
// a reference memory, and a scoreboard of expected load write-backs.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_unsigned_i;
  logic [1:0]  ex_op_i, ex_size_i;
  logic [31:0] ex_addr_i, ex_wdata_i;
  logic [4:0]  ex_rd_i;
  logic        stall_o, wb_valid_o, misaligned_o, cache_write_valid_o;
  logic [31:0] wb_data_o, cache_addr_o, cache_wdata_o;
  logic [4:0]  wb_rd_o;
  logic        cache_valid_i = 1'b0;
  logic [31:0] cache_rdata_i = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .ex_size_i(ex_size_i),
    .ex_unsigned_i(ex_unsigned_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
    .ex_rd_i(ex_rd_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .misaligned_o(misaligned_o),
    .cache_write_valid_o(cache_write_valid_o), .cache_addr_o(cache_addr_o),
    .cache_wdata_o(cache_wdata_o), .cache_valid_i(cache_valid_i),
    .cache_rdata_i(cache_rdata_i)
  );

  int errors = 0, checks = 0;
  int lat = 0, cnt = 0;
  int mis_seen = 0, mis_exp = 0, wb_seen = 0, ld_exp = 0;
  logic [31:0] mem [16];
  logic [31:0] refm [16];
  logic [36:0] sbq [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Cache model: valid after 'lat' wait cycles in every access state.
  always @(negedge clk) begin
    if (!stall_o) begin
      cache_valid_i = 1'b0;
      cnt = 0;
    end else if (cnt >= lat) begin
      cache_valid_i = 1'b1;
      cache_rdata_i = mem[cache_addr_o[3:0]];
      cnt = 0;
    end else begin
      cache_valid_i = 1'b0;
      cnt++;
    end
  end

  always @(posedge clk)
    if (cache_valid_i && cache_write_valid_o) mem[cache_addr_o[3:0]] <= cache_wdata_o;

  // Scoreboard consumer.
  always @(negedge clk) begin
    logic [36:0] e;
    if (misaligned_o) mis_seen++;
    if (wb_valid_o) begin
      wb_seen++;
      if (sbq.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wb_data", wb_data_o, e[31:0]);
        chk("wb_rd", {27'b0, wb_rd_o}, {27'b0, e[36:32]});
      end
    end
  end

  function automatic logic [31:0] mload(input logic [1:0] size, input logic uns,
                                        input logic [31:0] addr);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = refm[addr[5:2]];
    b = w[8*int'(addr[1:0]) +: 8];
    h = w[16*int'(addr[1]) +: 16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Drive one request at a negedge in IDLE; returns at the negedge of cycle N+1.
  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    logic bad;
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 0);
    if (op == 2'b01 || op == 2'b10) begin
      if (bad) mis_exp++;
      else if (op == 2'b01) begin
        sbq.push_back({rd, mload(size, uns, addr)});
        ld_exp++;
      end else begin
        case (size)
          2'b00:   refm[addr[5:2]][8*int'(addr[1:0]) +: 8] = wdata[7:0];
          2'b01:   refm[addr[5:2]][16*int'(addr[1]) +: 16] = wdata[15:0];
          default: refm[addr[5:2]] = wdata;
        endcase
      end
    end
    ex_valid_i = 1'b1; ex_op_i = op; ex_size_i = size; ex_unsigned_i = uns;
    ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
    @(posedge clk);
    @(negedge clk);
    ex_valid_i = 1'b0; ex_op_i = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, stall_o}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
    chk({tag, "_strobe"}, {31'b0, cache_write_valid_o}, 32'd0);
    chk({tag, "_addr"}, cache_addr_o, 32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    int n;
    rst_n = 1'b0;
    ex_valid_i = 0; ex_op_i = 0; ex_size_i = 0; ex_unsigned_i = 0;
    ex_addr_i = 0; ex_wdata_i = 0; ex_rd_i = 0;
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
    chk("rst_mis", {31'b0, misaligned_o}, 32'd0);
    chk("rst_wdata", cache_wdata_o, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill memory through word stores.
    for (int i = 0; i < 16; i++) begin
      issue(2'b10, 2'b10, 1'b0, 32'(i * 4), $urandom, 5'd0);
      wait_idle();
    end

    // Word load, immediate cache response.
    issue(2'b10, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
    wait_idle();
    issue(2'b01, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7);
    chk("ldw_stall_n1", {31'b0, stall_o}, 32'd1);
    chk("ldw_addr_n1", cache_addr_o, 32'h4);
    @(negedge clk);
    chk("ldw_wb_n2", {31'b0, wb_valid_o}, 32'd1);
    chk("ldw_data_n2", wb_data_o, 32'hDEADBEEF);
    chk("ldw_stall_n2", {31'b0, stall_o}, 32'd0);

    // Sub-word load extension.
    issue(2'b10, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 5'd0); wait_idle();
    issue(2'b01, 2'b00, 1'b0, 32'h13, 32'h0, 5'd1); wait_idle();
    issue(2'b01, 2'b00, 1'b1, 32'h13, 32'h0, 5'd2); wait_idle();
    issue(2'b01, 2'b01, 1'b0, 32'h12, 32'h0, 5'd3); wait_idle();
    @(negedge clk);
    chk("ldh_signed", wb_data_o, 32'hFFFF80FF);

    // Byte store read-modify-write.
    issue(2'b10, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd0); wait_idle();
    issue(2'b10, 2'b00, 1'b0, 32'h21, 32'h000000AB, 5'd0);
    chk("sb_stall_n1", {31'b0, stall_o}, 32'd1);
    chk("sb_strobe_n1", {31'b0, cache_write_valid_o}, 32'd0);
    chk("sb_addr_n1", cache_addr_o, 32'h8);
    @(negedge clk);
    chk("sb_stall_n2", {31'b0, stall_o}, 32'd1);
    chk("sb_strobe_n2", {31'b0, cache_write_valid_o}, 32'd1);
    chk("sb_addr_n2", cache_addr_o, 32'h8);
    chk("sb_wdata_n2", cache_wdata_o, 32'h1122AB44);
    @(negedge clk);
    chk("sb_stall_n3", {31'b0, stall_o}, 32'd0);
    chk("sb_wb_n3", {31'b0, wb_valid_o}, 32'd0);
    issue(2'b01, 2'b10, 1'b0, 32'h20, 32'h0, 5'd4); wait_idle();

    // Slow cache: three wait cycles.
    lat = 3;
    issue(2'b01, 2'b10, 1'b0, 32'h20, 32'h0, 5'd9);
    n = 0;
    while (stall_o && n < 50) begin
      chk("slow_addr_held", cache_addr_o, 32'h8);
      n++;
      @(negedge clk);
    end
    chk("slow_stall_cycles", 32'(n), 32'd4);
    chk("slow_wb", {31'b0, wb_valid_o}, 32'd1);
    lat = 0;

    // Rejections and reserved op.
    issue(2'b01, 2'b10, 1'b0, 32'h2, 32'h0, 5'd5);
    chk("mis_w_pulse", {31'b0, misaligned_o}, 32'd1); chk_quiet("mis_w");
    issue(2'b01, 2'b01, 1'b0, 32'h5, 32'h0, 5'd5);
    chk("mis_h_pulse", {31'b0, misaligned_o}, 32'd1); chk_quiet("mis_h");
    issue(2'b10, 2'b11, 1'b0, 32'h8, 32'h0, 5'd5);
    chk("mis_sz_pulse", {31'b0, misaligned_o}, 32'd1); chk_quiet("mis_sz");
    issue(2'b11, 2'b10, 1'b0, 32'h8, 32'h0, 5'd5);
    chk("rsvd_mis", {31'b0, misaligned_o}, 32'd0); chk_quiet("rsvd");

    // Reset while a word store waits in ST: the write must be abandoned.
    lat = 100;
    saved = refm[9];
    issue(2'b10, 2'b10, 1'b0, 32'h24, 32'h5555AAAA, 5'd0);
    refm[9] = saved;
    chk("rst_st_strobe", {31'b0, cache_write_valid_o}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("rst_mid");
    chk("rst_mid_wdata", cache_wdata_o, 32'd0);
    rst_n = 1'b1;
    lat = 0;
    issue(2'b01, 2'b10, 1'b0, 32'h24, 32'h0, 5'd6); wait_idle();

    // Random back-to-back traffic.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 2));
      a = $urandom_range(0, 63);
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      lat = $urandom_range(0, 2);
      issue($urandom_range(0, 1) ? 2'b01 : 2'b10, sz, 1'($urandom), a, $urandom, 5'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("wb_count", 32'(wb_seen), 32'(ld_exp));
    chk("mis_count", 32'(mis_seen), 32'(mis_exp));
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], refm[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
